// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned shift-and-add multiplier.
// One 2*WIDTH-bit ripple adder is time-shared across the iterations, and
// one multiplier bit is consumed per clock.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready operand handshake; in_ready is high only in IDLE
//   a, b                WIDTH-bit unsigned multiplicand / multiplier
//   out_valid/out_ready product handshake; out_valid is high only in DONE
//   p                   2*WIDTH-bit product, holds the last result outside DONE
//   busy                high while iterating (CALC)
//
// Optional build macro: SHIFT_ADD_MULT_EARLY_TERM_EN
//   Ends CALC as soon as no set multiplier bits remain.

module shift_add_mult_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  // Shared ripple-carry adder: acc + mcand, carry-in tied low.
  // The final carry-out is never formed since the product fits in PW bits.
  logic [PW-1:0] add_sum_c;
  logic [PW-1:0] add_carry_c;

  assign add_carry_c[0] = 1'b0;

  for (genvar i = 0; i < PW; i++) begin : g_rca
    assign add_sum_c[i] = acc_q[i] ^ mcand_q[i] ^ add_carry_c[i];
    if (i < PW - 1) begin : g_carry
      assign add_carry_c[i+1] = (acc_q[i] & mcand_q[i]) |
                                (acc_q[i] & add_carry_c[i]) |
                                (mcand_q[i] & add_carry_c[i]);
    end
  end

  // Last iteration detect.
  logic calc_last_c;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  // Stop once the shifted multiplier has no set bits left.
  assign calc_last_c = (count_q == LAST_CNT) || ((mplier_q >> 1) == '0);
`else
  assign calc_last_c = (count_q == LAST_CNT);
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    p_d         = p_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (mplier_q[0]) begin
          acc_d = add_sum_c;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (calc_last_c) begin
          state_d = S_DONE;
          // Product becomes visible together with out_valid.
          p_d     = acc_d;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_CALC);
    out_valid_d = (state_d == S_DONE);
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule
